// File: rtl/br_reslv_queue_pkg.sv
// Shared types and constants for the branch resolution queue and the
// direction predictor it feeds.
`ifndef SD
`define SD
`endif

package br_reslv_queue_pkg;

  localparam int BR_STATE_W = 2;

  localparam logic [BR_STATE_W-1:0] BR_NONE       = 2'b00;
  localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = 2'b01;
  localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = 2'b10;

  // Default branch history width; must match the predictor.
  localparam int BRQ_BHR_W = 8;

  // Resolve state reported to the predictor for a retired branch.
  function automatic logic [BR_STATE_W-1:0] brq_resolve(input logic pred, input logic taken);
    return (pred == taken) ? BR_PR_CORRECT : BR_PR_WRONG;
  endfunction

endpackage

// File: rtl/brq_ptr.sv
// Wrap-bit head/tail pointer pair with full, empty and occupancy.
// A flush retires the head entry and collapses the tail onto the new head.
module brq_ptr #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [IDX_W-1:0] head_idx_o,
  output logic [IDX_W-1:0] tail_idx_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [IDX_W:0]   count_o
);

  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0] head_q, head_d;
  logic [IDX_W:0] tail_q, tail_d;

  // Next pointer values; flush wins over push so wrong-path dispatches vanish.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop || flush) head_d = head_q + PTR_ONE;
    if (flush)        tail_d = head_q + PTR_ONE;
    else if (push)    tail_d = tail_q + PTR_ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_idx_o = head_q[IDX_W-1:0];
  assign tail_idx_o = tail_q[IDX_W-1:0];
  assign empty_o    = (head_q == tail_q);
  assign full_o     = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign count_o    = tail_q - head_q;

endmodule

// File: rtl/br_reslv_queue.sv
// In-order branch resolution queue: records predictions at dispatch,
// takes execute outcomes out of order by tag, retires oldest-first and
// drives the predictor resolve interface; a mispredict flushes all younger.
module br_reslv_queue
  import br_reslv_queue_pkg::*;
#(
  parameter int BRQ_DEPTH = 8,
  parameter int BRQ_IDX_W = $clog2(BRQ_DEPTH),
  parameter int BHR_W     = BRQ_BHR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_br_i,
  input  logic                  disp_pred_i,
  input  logic [BHR_W-1:0]      disp_bhr_i,
  output logic [BRQ_IDX_W-1:0]  disp_tag_o,
  output logic                  full_o,
  input  logic                  ex_valid_i,
  input  logic [BRQ_IDX_W-1:0]  ex_tag_i,
  input  logic                  ex_taken_i,
  output logic [BR_STATE_W-1:0] reslv_o,
  output logic                  is_taken_o,
  output logic [BHR_W-1:0]      recrv_BHR_o,
  output logic                  squash_o,
  output logic [BRQ_IDX_W:0]    count_o
);

  logic [BRQ_IDX_W-1:0] head_idx, tail_idx;
  logic                 empty, retire, mispredict, push;

  logic [BRQ_DEPTH-1:0] valid_q, valid_d;
  logic [BRQ_DEPTH-1:0] done_q, done_d;
  logic [BRQ_DEPTH-1:0] pred_q, pred_d;
  logic [BRQ_DEPTH-1:0] taken_q, taken_d;
  logic [BHR_W-1:0]     bhr_q [BRQ_DEPTH];
  logic [BHR_W-1:0]     bhr_d [BRQ_DEPTH];

  logic [BR_STATE_W-1:0] reslv_q, reslv_d;
  logic                  is_taken_q, is_taken_d;
  logic [BHR_W-1:0]      recrv_bhr_q, recrv_bhr_d;
  logic                  squash_q, squash_d;

  brq_ptr #(.IDX_W(BRQ_IDX_W)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (retire),
    .flush      (mispredict),
    .head_idx_o (head_idx),
    .tail_idx_o (tail_idx),
    .full_o     (full_o),
    .empty_o    (empty),
    .count_o    (count_o)
  );

  // Retire decision uses only registered state, so a same-cycle execute
  // write to the head is seen one cycle later at the earliest.
  always_comb begin
    retire     = !empty && valid_q[head_idx] && done_q[head_idx];
    mispredict = retire && (taken_q[head_idx] != pred_q[head_idx]);
    push       = disp_br_i && !full_o && !mispredict;
  end

  // Entry updates: execute write, then dispatch, then retire/flush clears.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    pred_d  = pred_q;
    taken_d = taken_q;
    bhr_d   = bhr_q;
    if (ex_valid_i && valid_q[ex_tag_i]) begin
      done_d[ex_tag_i]  = 1'b1;
      taken_d[ex_tag_i] = ex_taken_i;
    end
    if (push) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      pred_d[tail_idx]  = disp_pred_i;
      bhr_d[tail_idx]   = disp_bhr_i;
    end
    if (retire)     valid_d[head_idx] = 1'b0;
    if (mispredict) valid_d = '0;
  end

  // Resolve outputs for the next cycle; direction and BHR hold when idle.
  always_comb begin
    reslv_d     = BR_NONE;
    is_taken_d  = is_taken_q;
    recrv_bhr_d = recrv_bhr_q;
    squash_d    = mispredict;
    if (retire) begin
      reslv_d     = brq_resolve(pred_q[head_idx], taken_q[head_idx]);
      is_taken_d  = taken_q[head_idx];
      recrv_bhr_d = bhr_q[head_idx];
    end
  end

  // Entry and output registers; payload fields need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      done_q      <= '0;
      reslv_q     <= BR_NONE;
      is_taken_q  <= 1'b0;
      recrv_bhr_q <= '0;
      squash_q    <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      pred_q      <= pred_d;
      taken_q     <= taken_d;
      bhr_q       <= bhr_d;
      reslv_q     <= reslv_d;
      is_taken_q  <= is_taken_d;
      recrv_bhr_q <= recrv_bhr_d;
      squash_q    <= squash_d;
    end
  end

  assign disp_tag_o  = tail_idx;
  assign reslv_o     = reslv_q;
  assign is_taken_o  = is_taken_q;
  assign recrv_BHR_o = recrv_bhr_q;
  assign squash_o    = squash_q;

endmodule

// File: tb/tb_br_reslv_queue.sv
// Bench for br_reslv_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_br_reslv_queue;
  import br_reslv_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int BW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_br = 1'b0;
  logic          disp_pred = 1'b0;
  logic [BW-1:0] disp_bhr = '0;
  logic [IW-1:0] disp_tag;
  logic          full;
  logic          ex_valid = 1'b0;
  logic [IW-1:0] ex_tag = '0;
  logic          ex_taken = 1'b0;
  logic [1:0]    reslv;
  logic          is_taken;
  logic [BW-1:0] recrv_bhr;
  logic          squash;
  logic [IW:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  br_reslv_queue #(.BRQ_DEPTH(DEPTH), .BHR_W(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_br_i   (disp_br),
    .disp_pred_i (disp_pred),
    .disp_bhr_i  (disp_bhr),
    .disp_tag_o  (disp_tag),
    .full_o      (full),
    .ex_valid_i  (ex_valid),
    .ex_tag_i    (ex_tag),
    .ex_taken_i  (ex_taken),
    .reslv_o     (reslv),
    .is_taken_o  (is_taken),
    .recrv_BHR_o (recrv_bhr),
    .squash_o    (squash),
    .count_o     (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a plain in-order queue ----------------
  typedef struct {
    int            tag;
    logic          pred;
    logic [BW-1:0] bhr;
    logic          done;
    logic          taken;
  } ent_t;

  ent_t          mq[$];
  int            m_tail = 0;
  logic [1:0]    m_reslv = BR_NONE;
  logic          m_taken = 1'b0;
  logic [BW-1:0] m_bhr = '0;
  logic          m_squash = 1'b0;
  bit            model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_tail = 0; m_reslv = BR_NONE; m_taken = 1'b0; m_bhr = '0; m_squash = 1'b0;
      model_live = 1'b1;
    end else begin
      bit   ret, wrong, was_full;
      ent_t h;
      was_full = (mq.size() == DEPTH);
      ret      = (mq.size() > 0) && mq[0].done;
      wrong    = 1'b0;
      if (ret) begin
        h     = mq[0];
        wrong = (h.taken != h.pred);
      end
      if (ex_valid)
        foreach (mq[i])
          if (mq[i].tag == int'(ex_tag)) begin
            mq[i].done  = 1'b1;
            mq[i].taken = ex_taken;
          end
      if (ret) begin
        void'(mq.pop_front());
        m_reslv = wrong ? BR_PR_WRONG : BR_PR_CORRECT;
        m_taken = h.taken;
        m_bhr   = h.bhr;
      end else begin
        m_reslv = BR_NONE;
      end
      m_squash = wrong;
      if (wrong) begin
        mq.delete();
        m_tail = (h.tag + 1) % DEPTH;
      end
      if (disp_br && !was_full && !wrong) begin
        mq.push_back('{m_tail, disp_pred, disp_bhr, 1'b0, 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("m_reslv",    32'(reslv),     32'(m_reslv));
      chk("m_is_taken", 32'(is_taken),  32'(m_taken));
      chk("m_bhr",      32'(recrv_bhr), 32'(m_bhr));
      chk("m_squash",   32'(squash),    32'(m_squash));
      chk("m_count",    32'(count),     32'(mq.size()));
      chk("m_full",     32'(full),      32'(mq.size() == DEPTH));
      chk("m_tag",      32'(disp_tag),  32'(m_tail));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    disp_br = 1'b0; ex_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic p, input logic [BW-1:0] b);
    disp_br = 1'b1; disp_pred = p; disp_bhr = b; ex_valid = 1'b0;
    tick();
    disp_br = 1'b0;
  endtask

  task automatic ex(input logic [IW-1:0] t, input logic tk);
    ex_valid = 1'b1; ex_tag = t; ex_taken = tk; disp_br = 1'b0;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset then idle.
    tick(); tick(); tick();
    chk("rst_reslv", 32'(reslv), 32'(BR_NONE));
    chk("rst_count", 32'(count), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_tag",   32'(disp_tag), 0);

    // Single correct prediction.
    dispatch(1'b1, 8'hA5);
    chk("t1_count1", 32'(count), 1);
    chk("t1_tag1",   32'(disp_tag), 1);
    ex(3'd0, 1'b1);
    chk("t1_nobypass", 32'(reslv), 32'(BR_NONE));
    tick();
    chk("t1_reslv", 32'(reslv), 32'(BR_PR_CORRECT));
    chk("t1_taken", 32'(is_taken), 1);
    chk("t1_bhr",   32'(recrv_bhr), 32'h A5);
    chk("t1_count", 32'(count), 0);
    tick();
    chk("t1_pulse", 32'(reslv), 32'(BR_NONE));
    chk("t1_hold",  32'(recrv_bhr), 32'h A5);

    // Out-of-order completion, in-order retire.
    do_reset();
    dispatch(1'b0, 8'h10);
    dispatch(1'b0, 8'h11);
    dispatch(1'b0, 8'h12);
    ex(3'd2, 1'b0);
    ex(3'd1, 1'b0);
    chk("t2_wait", 32'(reslv), 32'(BR_NONE));
    ex(3'd0, 1'b0);
    tick();
    chk("t2_r0", 32'(reslv), 32'(BR_PR_CORRECT));
    chk("t2_b0", 32'(recrv_bhr), 32'h10);
    tick();
    chk("t2_r1", 32'(reslv), 32'(BR_PR_CORRECT));
    chk("t2_b1", 32'(recrv_bhr), 32'h11);
    tick();
    chk("t2_r2", 32'(reslv), 32'(BR_PR_CORRECT));
    chk("t2_b2", 32'(recrv_bhr), 32'h12);
    chk("t2_cnt", 32'(count), 0);

    // Mispredict flush.
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(1'b1, 8'(8'h20 + i));
    ex(3'd1, 1'b1);
    ex(3'd3, 1'b1);
    ex(3'd0, 1'b0);
    disp_br = 1'b1; disp_pred = 1'b1; disp_bhr = 8'hEE;
    ex_valid = 1'b1; ex_tag = 3'd3; ex_taken = 1'b0;
    tick();
    idle_in();
    chk("t3_reslv",  32'(reslv), 32'(BR_PR_WRONG));
    chk("t3_taken",  32'(is_taken), 0);
    chk("t3_squash", 32'(squash), 1);
    chk("t3_bhr",    32'(recrv_bhr), 32'h20);
    chk("t3_count",  32'(count), 0);
    chk("t3_tag",    32'(disp_tag), 1);
    ex(3'd3, 1'b1);
    chk("t3_ign_r", 32'(reslv), 32'(BR_NONE));
    chk("t3_ign_s", 32'(squash), 0);
    chk("t3_ign_c", 32'(count), 0);
    tick();
    chk("t3_ign_r2", 32'(reslv), 32'(BR_NONE));
    dispatch(1'b0, 8'h55);
    chk("t3_cnt1", 32'(count), 1);
    chk("t3_tag2", 32'(disp_tag), 2);

    // Full, dropped dispatch, wrap.
    do_reset();
    for (int i = 0; i < 8; i++) dispatch(1'b0, 8'(8'h30 + i));
    chk("t4_full",  32'(full), 1);
    chk("t4_cnt8",  32'(count), 8);
    chk("t4_tagw",  32'(disp_tag), 0);
    dispatch(1'b1, 8'hFF);
    chk("t4_drop",  32'(count), 8);
    ex(3'd0, 1'b0);
    chk("t4_still", 32'(full), 1);
    tick();
    chk("t4_r",     32'(reslv), 32'(BR_PR_CORRECT));
    chk("t4_b",     32'(recrv_bhr), 32'h30);
    chk("t4_nfull", 32'(full), 0);
    chk("t4_cnt7",  32'(count), 7);
    chk("t4_tag0",  32'(disp_tag), 0);
    dispatch(1'b1, 8'h77);
    chk("t4_refill", 32'(count), 8);
    chk("t4_refull", 32'(full), 1);

    // Reset mid-operation with an execute write pending.
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(1'b1, 8'(8'h40 + i));
    ex_valid = 1'b1; ex_tag = 3'd0; ex_taken = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; ex_valid = 1'b0;
    chk("t5_cnt",   32'(count), 0);
    chk("t5_reslv", 32'(reslv), 32'(BR_NONE));
    chk("t5_sq",    32'(squash), 0);
    tick();
    chk("t5_reslv2", 32'(reslv), 32'(BR_NONE));
    chk("t5_sq2",    32'(squash), 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      disp_br   = ($urandom_range(0, 9) < 6);
      disp_pred = 1'($urandom);
      disp_bhr  = 8'($urandom);
      ex_valid  = ($urandom_range(0, 9) < 5);
      ex_taken  = 1'($urandom);
      ex_tag    = 3'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
        int k;
        k        = $urandom_range(0, mq.size() - 1);
        ex_tag   = 3'(mq[k].tag);
        ex_taken = ($urandom_range(0, 9) < 8) ? mq[k].pred : !mq[k].pred;
      end
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
